dpbram_xchg: RTL and testbench

Parameterised frame engine for the XINTF dual-port BRAM link between the Zynq PL and the DSP. On each start request it streams a snapshot of C_W_WORDS 16-bit words into the write DPBRAM. It then reads C_R_WORDS words back from the read DPBRAM through a pipelined port with C_RAM_LAT latency, and publishes them atomically. It sits between the AXI register bank and the two DPBRAMs, replacing the fixed-map handler. It adds interlock injection, frame/overrun counters and a DSP heartbeat watchdog.

---
 rtl/dpbram_xchg_if.sv | 24 ++
 rtl/dpbram_xchg.sv | 189 ++++++++++++++++++
 tb/tb_dpbram_xchg.sv | 237 +++++++++++++++++++++++
 3 files changed

// File: rtl/dpbram_xchg_if.sv
// DPBRAM port bundle for the XINTF exchange engine: one write port and one pipelined read port.
interface dpbram_xchg_if #(
    parameter int C_ADDR_WIDTH = 9
) ();
    logic [C_ADDR_WIDTH-1:0] o_w_ram_addr;
    logic [15:0]             o_w_ram_din;
    logic                    o_w_ram_ce;
    logic                    o_w_ram_we;
    logic [C_ADDR_WIDTH-1:0] o_r_ram_addr;
    logic                    o_r_ram_ce;
    logic [15:0]             i_r_ram_dout;

    modport master (
        output o_w_ram_addr, o_w_ram_din, o_w_ram_ce, o_w_ram_we,
        output o_r_ram_addr, o_r_ram_ce,
        input  i_r_ram_dout
    );

    modport slave (
        input  o_w_ram_addr, o_w_ram_din, o_w_ram_ce, o_w_ram_we,
        input  o_r_ram_addr, o_r_ram_ce,
        output i_r_ram_dout
    );
endinterface

// File: rtl/dpbram_xchg.sv
// Frame engine: writes a latched snapshot to the write DPBRAM, reads a frame back and publishes it atomically.
// Optional DSP heartbeat watchdog is compiled in when DPBRAM_XCHG_HB_EN is defined.
module dpbram_xchg #(
    parameter int C_W_WORDS    = 40,
    parameter int C_R_WORDS    = 24,
    parameter int C_ADDR_WIDTH = 9,
    parameter int C_W_BASE     = 0,
    parameter int C_R_BASE     = 0,
    parameter int C_RAM_LAT    = 1,
    parameter int C_HB_TIMEOUT = 100000
) (
    input  logic                     i_clk,
    input  logic                     i_rst,
    input  logic                     i_start,
    input  logic                     i_intl,
    input  logic [16*C_W_WORDS-1:0]  i_w_data,
    output logic [16*C_R_WORDS-1:0]  o_r_data,
    output logic                     o_r_valid,
    output logic                     o_busy,
    output logic [15:0]              o_frame_cnt,
    output logic [15:0]              o_overrun_cnt,
    input  logic                     i_clr_timeout,
    output logic                     o_dsp_timeout,
    dpbram_xchg_if.master            ram
);
    localparam int WIW = (C_W_WORDS > 1) ? $clog2(C_W_WORDS) : 1;
    localparam int RIW = (C_R_WORDS > 1) ? $clog2(C_R_WORDS) : 1;

    typedef enum logic [2:0] {IDLE, WRITE, READ, DRAIN, DONE} state_t;

    state_t                          state_q, state_d;
    logic [8:0]                      k_q, k_d;
    logic [C_W_WORDS-1:0][15:0]      snap_q;
    logic                            intl_q;
    logic [C_RAM_LAT-1:0]            tagV_q;
    logic [C_RAM_LAT-1:0][RIW-1:0]   tagI_q;
    logic [C_R_WORDS-1:0][15:0]      shadow_q, shadow_d, rdata_q;
    logic                            rvalid_q;
    logic [15:0]                     frame_q, over_q;
    logic                            issue;
    logic [31:0]                     wSum, rSum;

    assign wSum = 32'(C_W_BASE) + 32'(k_q);
    assign rSum = 32'(C_R_BASE) + 32'(k_q);

    always_comb begin
        state_d           = state_q;
        k_d               = k_q;
        issue             = 1'b0;
        ram.o_w_ram_addr  = '0;
        ram.o_w_ram_din   = '0;
        ram.o_w_ram_ce    = 1'b0;
        ram.o_w_ram_we    = 1'b0;
        ram.o_r_ram_addr  = '0;
        ram.o_r_ram_ce    = 1'b0;
        case (state_q)
            IDLE: begin
                if (i_start) begin
                    state_d = WRITE;
                    k_d     = '0;
                end
            end
            WRITE: begin
                ram.o_w_ram_ce   = 1'b1;
                ram.o_w_ram_we   = 1'b1;
                ram.o_w_ram_addr = wSum[C_ADDR_WIDTH-1:0];
                ram.o_w_ram_din  = snap_q[k_q[WIW-1:0]];
                // The interlock is forced into bit 0 of the first word only.
                if (k_q == '0) ram.o_w_ram_din[0] = snap_q[0][0] | intl_q;
                if (k_q == 9'(C_W_WORDS - 1)) begin
                    state_d = READ;
                    k_d     = '0;
                end else begin
                    k_d = k_q + 9'd1;
                end
            end
            READ: begin
                ram.o_r_ram_ce   = 1'b1;
                ram.o_r_ram_addr = rSum[C_ADDR_WIDTH-1:0];
                issue            = 1'b1;
                if (k_q == 9'(C_R_WORDS - 1)) begin
                    state_d = DRAIN;
                    k_d     = '0;
                end else begin
                    k_d = k_q + 9'd1;
                end
            end
            DRAIN: begin
                if (k_q == 9'(C_RAM_LAT - 1)) begin
                    state_d = DONE;
                    k_d     = '0;
                end else begin
                    k_d = k_q + 9'd1;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        shadow_d = shadow_q;
        if (tagV_q[C_RAM_LAT-1]) shadow_d[tagI_q[C_RAM_LAT-1]] = ram.i_r_ram_dout;
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst) begin
            state_q  <= IDLE;
            k_q      <= '0;
            snap_q   <= '0;
            intl_q   <= 1'b0;
            tagV_q   <= '0;
            tagI_q   <= '0;
            shadow_q <= '0;
            rdata_q  <= '0;
            rvalid_q <= 1'b0;
            frame_q  <= '0;
            over_q   <= '0;
        end else begin
            state_q  <= state_d;
            k_q      <= k_d;
            shadow_q <= shadow_d;
            if (state_q == IDLE && i_start) begin
                snap_q <= i_w_data;
                intl_q <= i_intl;
            end
            tagV_q[0] <= issue;
            tagI_q[0] <= k_q[RIW-1:0];
            for (int j = 1; j < C_RAM_LAT; j++) begin
                tagV_q[j] <= tagV_q[j-1];
                tagI_q[j] <= tagI_q[j-1];
            end
            // Publish on entry to DONE so data and pulse appear together, including the final capture.
            rvalid_q <= (state_d == DONE);
            if (state_d == DONE) begin
                rdata_q <= shadow_d;
                frame_q <= frame_q + 16'd1;
            end
            if (state_q != IDLE && i_start && over_q != 16'hFFFF) over_q <= over_q + 16'd1;
        end
    end

    assign o_r_data      = rdata_q;
    assign o_r_valid     = rvalid_q;
    assign o_busy        = (state_q != IDLE);
    assign o_frame_cnt   = frame_q;
    assign o_overrun_cnt = over_q;

`ifdef DPBRAM_XCHG_HB_EN
    localparam int TW = $clog2(C_HB_TIMEOUT + 1);

    logic [TW-1:0] hbCnt_q, hbCnt_d;
    logic [15:0]   hbPrev_q;
    logic          timeout_q;
    logic          hbChange;

    assign hbChange = (state_q == DONE) && (rdata_q[C_R_WORDS-1] != hbPrev_q);

    always_comb begin
        hbCnt_d = hbCnt_q;
        if (hbChange) hbCnt_d = '0;
        else if (hbCnt_q != TW'(C_HB_TIMEOUT)) hbCnt_d = hbCnt_q + TW'(1);
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst) begin
            hbCnt_q   <= '0;
            hbPrev_q  <= '0;
            timeout_q <= 1'b0;
        end else begin
            if (state_q == DONE) hbPrev_q <= rdata_q[C_R_WORDS-1];
            if (i_clr_timeout) begin
                hbCnt_q   <= '0;
                timeout_q <= 1'b0;
            end else begin
                hbCnt_q <= hbCnt_d;
                if (hbCnt_d == TW'(C_HB_TIMEOUT)) timeout_q <= 1'b1;
            end
        end
    end

    assign o_dsp_timeout = timeout_q;
`else
    localparam int unusedTimeout = C_HB_TIMEOUT;
    logic unusedClr;
    assign unusedClr     = i_clr_timeout;
    assign o_dsp_timeout = 1'b0;
`endif
endmodule

// File: tb/tb_dpbram_xchg.sv
// Self-checking bench for dpbram_xchg: two configurations driven in lockstep against a cycle-schedule reference model.
module tb_dpbram_xchg;
    localparam int AW = 9;
    localparam int TO = 50;

    int W[2]   = '{4, 4};
    int R[2]   = '{3, 2};
    int LAT[2] = '{1, 3};
    int WB[2]  = '{0, 510};
    int RB[2]  = '{0, 5};

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rstN, start, intl, clr;
    logic [63:0] wdata;

    dpbram_xchg_if #(.C_ADDR_WIDTH(AW)) ifA ();
    dpbram_xchg_if #(.C_ADDR_WIDTH(AW)) ifB ();

    logic        busy[2], rvalid[2], tout[2], wce[2], wwe[2], rce[2];
    logic [15:0] fcnt[2], ocnt[2], wdin[2];
    logic [8:0]  waddr[2], raddr[2];
    logic [63:0] rdata[2];
    logic [47:0] rdA;
    logic [31:0] rdB;

    dpbram_xchg #(.C_W_WORDS(4), .C_R_WORDS(3), .C_ADDR_WIDTH(AW), .C_W_BASE(0), .C_R_BASE(0),
                  .C_RAM_LAT(1), .C_HB_TIMEOUT(TO)) dutA (
        .i_clk(clk), .i_rst(rstN), .i_start(start), .i_intl(intl), .i_w_data(wdata),
        .o_r_data(rdA), .o_r_valid(rvalid[0]), .o_busy(busy[0]), .o_frame_cnt(fcnt[0]),
        .o_overrun_cnt(ocnt[0]), .i_clr_timeout(clr), .o_dsp_timeout(tout[0]), .ram(ifA)
    );

    dpbram_xchg #(.C_W_WORDS(4), .C_R_WORDS(2), .C_ADDR_WIDTH(AW), .C_W_BASE(510), .C_R_BASE(5),
                  .C_RAM_LAT(3), .C_HB_TIMEOUT(TO)) dutB (
        .i_clk(clk), .i_rst(rstN), .i_start(start), .i_intl(intl), .i_w_data(wdata),
        .o_r_data(rdB), .o_r_valid(rvalid[1]), .o_busy(busy[1]), .o_frame_cnt(fcnt[1]),
        .o_overrun_cnt(ocnt[1]), .i_clr_timeout(clr), .o_dsp_timeout(tout[1]), .ram(ifB)
    );

    assign rdata[0] = 64'(rdA);
    assign rdata[1] = 64'(rdB);
    assign wce[0]   = ifA.o_w_ram_ce;   assign wce[1]   = ifB.o_w_ram_ce;
    assign wwe[0]   = ifA.o_w_ram_we;   assign wwe[1]   = ifB.o_w_ram_we;
    assign waddr[0] = ifA.o_w_ram_addr; assign waddr[1] = ifB.o_w_ram_addr;
    assign wdin[0]  = ifA.o_w_ram_din;  assign wdin[1]  = ifB.o_w_ram_din;
    assign rce[0]   = ifA.o_r_ram_ce;   assign rce[1]   = ifB.o_r_ram_ce;
    assign raddr[0] = ifA.o_r_ram_addr; assign raddr[1] = ifB.o_r_ram_addr;

    // Reference model: each accepted frame is described only by its start cycle and latched inputs.
    int          n, compared, mismatched;
    int          fs[2];
    bit          act[2], sIntl[2], hbFlag[2];
    logic [63:0] snap[2], pub[2];
    logic [15:0] expR[2][4];
    logic [15:0] mFc[2], mOc[2];
    logic [15:0] mem[2][512];
    logic [15:0] histV[2][8];
    bit          histOk[2][8];
`ifdef DPBRAM_XCHG_HB_EN
    int          hbCnt[2];
    logic [15:0] lastHb[2];
`endif

    task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("[TB] FAIL %s at cycle %0d: observed %0h expected %0h", tag, n, obs, exp);
        end
    endtask

    task automatic modelEdge();
        int p, d, rel;
        bit busyP;
        p = n - 1;
        for (int id = 0; id < 2; id++) begin
            d     = W[id] + R[id] + LAT[id] + 1;
            rel   = p - fs[id];
            busyP = act[id] && rel >= 1 && rel <= d;
            if (!rstN) begin
                act[id] = 1'b0; mFc[id] = '0; mOc[id] = '0; pub[id] = '0; hbFlag[id] = 1'b0;
`ifdef DPBRAM_XCHG_HB_EN
                hbCnt[id] = 0; lastHb[id] = '0;
`endif
            end else begin
`ifdef DPBRAM_XCHG_HB_EN
                if (clr) begin
                    hbCnt[id] = 0; hbFlag[id] = 1'b0;
                end else begin
                    if (act[id] && rel == d && pub[id][16*(R[id]-1) +: 16] != lastHb[id]) hbCnt[id] = 0;
                    else if (hbCnt[id] < TO) hbCnt[id]++;
                    if (hbCnt[id] == TO) hbFlag[id] = 1'b1;
                end
                if (act[id] && rel == d) lastHb[id] = pub[id][16*(R[id]-1) +: 16];
`endif
                if (start) begin
                    if (busyP) begin
                        if (mOc[id] != 16'hFFFF) mOc[id]++;
                    end else begin
                        act[id] = 1'b1; fs[id] = p; snap[id] = wdata; sIntl[id] = intl;
                    end
                end
            end
        end
    endtask

    task automatic checkCycle();
        string       pre;
        int          rel, d, back;
        bit          inF, wr, rd, v;
        logic [15:0] eDin, dout;
        logic [8:0]  eWa, eRa;
        for (int id = 0; id < 2; id++) begin
            pre  = (id == 0) ? "A" : "B";
            rel  = n - fs[id];
            d    = W[id] + R[id] + LAT[id] + 1;
            inF  = act[id] && rel >= 1 && rel <= d;
            wr   = act[id] && rel >= 1 && rel <= W[id];
            rd   = act[id] && rel >= W[id] + 1 && rel <= W[id] + R[id];
            v    = act[id] && rel == d;
            eDin = '0; eWa = '0; eRa = '0;
            if (wr) begin
                eDin = snap[id][16*(rel-1) +: 16];
                if (rel == 1) eDin[0] = eDin[0] | sIntl[id];
                eWa = 9'((WB[id] + rel - 1) % 512);
            end
            if (rd) begin
                eRa = 9'((RB[id] + rel - W[id] - 1) % 512);
                expR[id][rel-W[id]-1] = mem[id][eRa];
            end
            if (v) begin
                pub[id] = '0;
                for (int j = 0; j < R[id]; j++) pub[id][16*j +: 16] = expR[id][j];
                mFc[id]++;
            end
            checkOutput({pre, ".busy"},    64'(busy[id]),   64'(inF));
            checkOutput({pre, ".w_ce"},    64'(wce[id]),    64'(wr));
            checkOutput({pre, ".w_we"},    64'(wwe[id]),    64'(wr));
            checkOutput({pre, ".w_addr"},  64'(waddr[id]),  64'(eWa));
            checkOutput({pre, ".w_din"},   64'(wdin[id]),   64'(eDin));
            checkOutput({pre, ".r_ce"},    64'(rce[id]),    64'(rd));
            checkOutput({pre, ".r_addr"},  64'(raddr[id]),  64'(eRa));
            checkOutput({pre, ".r_valid"}, 64'(rvalid[id]), 64'(v));
            checkOutput({pre, ".r_data"},  rdata[id],       pub[id]);
            checkOutput({pre, ".frames"},  64'(fcnt[id]),   64'(mFc[id]));
            checkOutput({pre, ".overrun"}, 64'(ocnt[id]),   64'(mOc[id]));
            checkOutput({pre, ".timeout"}, 64'(tout[id]),   64'(hbFlag[id]));
            // Pipelined read port: data for an address issued at cycle c is presented at c+LAT.
            back = (n - LAT[id]) % 8;
            dout = (n >= LAT[id] && histOk[id][back]) ? histV[id][back] : 16'($urandom);
            if (id == 0) ifA.i_r_ram_dout = dout;
            else         ifB.i_r_ram_dout = dout;
            histOk[id][n%8] = rce[id];
            histV[id][n%8]  = mem[id][raddr[id]];
        end
    endtask

    task automatic tick();
        @(posedge clk);
        n++;
        modelEdge();
        #1;
        checkCycle();
    endtask

    task automatic applyStimulus(input bit rn, input bit st, input bit il, input logic [63:0] wd, input bit cl);
        rstN = rn; start = st; intl = il; wdata = wd; clr = cl;
        tick();
    endtask

    function automatic logic [63:0] rnd64();
        return {$urandom, $urandom};
    endfunction

    initial begin
        n = 0; compared = 0; mismatched = 0;
        rstN = 1'b0; start = 1'b0; intl = 1'b0; clr = 1'b0; wdata = '0;
        ifA.i_r_ram_dout = '0; ifB.i_r_ram_dout = '0;
        for (int id = 0; id < 2; id++) begin
            fs[id] = 0; act[id] = 1'b0;
            for (int j = 0; j < 8; j++) begin histOk[id][j] = 1'b0; histV[id][j] = '0; end
            for (int a = 0; a < 512; a++) mem[id][a] = 16'($urandom);
        end
        mem[0][0] = 16'h00A0; mem[0][1] = 16'h00A1; mem[0][2] = 16'h00A2;

        $display("[TB] reset");
        repeat (3) applyStimulus(0, 0, 0, '0, 0);
        repeat (6) applyStimulus(1, 0, 0, '0, 0);

        $display("[TB] single frame with interlock, snapshot isolation");
        applyStimulus(1, 1, 1, 64'h4444_3333_2222_1111, 0);
        repeat (15) applyStimulus(1, 0, 0, rnd64(), 0);

        $display("[TB] interlock injection into word 0 bit 0");
        applyStimulus(1, 1, 1, 64'h4444_3333_2222_1110, 0);
        repeat (15) applyStimulus(1, 0, 0, '0, 0);
        applyStimulus(1, 1, 0, 64'h4444_3333_2222_1110, 0);
        repeat (15) applyStimulus(1, 0, 0, '0, 0);

        $display("[TB] start held high for 30 cycles");
        repeat (30) applyStimulus(1, 1, 0, rnd64(), 0);
        repeat (15) applyStimulus(1, 0, 0, '0, 0);

        $display("[TB] reset mid-write, then a fresh frame");
        applyStimulus(1, 1, 1, rnd64(), 0);
        repeat (2) applyStimulus(1, 0, 0, '0, 0);
        applyStimulus(0, 0, 0, '0, 0);
        repeat (3) applyStimulus(1, 0, 0, '0, 0);
        applyStimulus(1, 1, 0, rnd64(), 0);
        repeat (15) applyStimulus(1, 0, 0, '0, 0);

        $display("[TB] randomized traffic");
        for (int c = 0; c < 600; c++) begin
            if ($urandom_range(0, 3) == 0) mem[$urandom_range(0, 1)][$urandom_range(0, 7)] = 16'($urandom);
            applyStimulus(($urandom_range(0, 199) != 0), ($urandom_range(0, 5) == 0),
                          1'($urandom), rnd64(), ($urandom_range(0, 49) == 0));
        end

        $display("[TB] heartbeat constant, then cleared, then incrementing");
        applyStimulus(1, 0, 0, '0, 1);
        for (int c = 0; c < 130; c++) applyStimulus(1, (c % 12 == 0), 0, rnd64(), 0);
        applyStimulus(1, 0, 0, '0, 1);
        for (int c = 0; c < 150; c++) begin
            if (c % 12 == 0) begin
                mem[0][2] = mem[0][2] + 16'd1;
                mem[1][6] = mem[1][6] + 16'd1;
            end
            applyStimulus(1, (c % 12 == 0), 0, rnd64(), 0);
        end
        repeat (5) applyStimulus(1, 0, 0, '0, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
